// File: rtl/keep_to_len.sv
// Beat-stream byte counter: sums thermometer keep popcounts per message and flags malformed masks/overflow.
// Define KEEP_MSB_EN for MSB-aligned keep masks; default is LSB-aligned.
module keep_to_len #(
  parameter int KEEP_W     = 8,
  parameter int KEEP_LEN_W = 4,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic              last_i,
  output logic              len_v_o,
  input  logic              len_ready_i,
  output logic [LEN_W-1:0]  len_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                state_q, state_n;
  logic [LEN_W-1:0]      acc_q, acc_n;
  logic                  err_q, err_n;

  logic [KEEP_LEN_W-1:0] blen;
  logic [KEEP_W-1:0]     thermo;
  logic                  legal, beat_err, accept, ovf;
  logic [LEN_W-1:0]      base_acc;
  logic                  base_err;
  logic [LEN_W:0]        sum;

  always_comb begin
    blen = '0;
    for (int i = 0; i < KEEP_W; i++) blen = blen + KEEP_LEN_W'(keep_i[i]);
  end

  // Reference thermometer for this popcount; the mask is legal only if it matches exactly.
`ifdef KEEP_MSB_EN
  assign thermo = ~({KEEP_W{1'b1}} >> blen);
`else
  assign thermo = ~({KEEP_W{1'b1}} << blen);
`endif

  assign legal    = (keep_i == thermo);
  assign beat_err = last_i ? !legal : !(&keep_i);

  assign ready_o = (state_q != DONE) || len_ready_i;
  assign accept  = valid_i && ready_o;

  // A beat outside ACC always starts a fresh message, including one accepted while DONE is draining.
  assign base_acc = (state_q == ACC) ? acc_q : '0;
  assign base_err = (state_q == ACC) ? err_q : 1'b0;
  assign sum      = {1'b0, base_acc} + (LEN_W+1)'(blen);
  assign ovf      = sum[LEN_W];

  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    err_n   = err_q;
    if (state_q == DONE && len_ready_i) begin
      state_n = IDLE;
      acc_n   = '0;
      err_n   = 1'b0;
    end
    if (accept) begin
      acc_n   = ovf ? '1 : sum[LEN_W-1:0];
      err_n   = base_err | beat_err | ovf;
      state_n = last_i ? DONE : ACC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      acc_q   <= acc_n;
      err_q   <= err_n;
    end
  end

  assign len_v_o = (state_q == DONE);
  assign len_o   = acc_q;
  assign err_o   = err_q;

endmodule

// File: doc/keep_to_len.md
# keep_to_len

Streaming byte counter, the inverse of the length-to-mask conversion: it consumes a beat stream of DATA_W-bit words, each qualified by a thermometer byte-keep mask, and returns the total byte length of each message once its last beat has been accepted. It also checks that every keep mask is a legal thermometer and that only the last beat is partial. It sits on the MoldUDP64 receive path, between the beat stream and the message length/sequence checker.

## Interface
- `KEEP_W`, default 8: bytes per beat (DATA_W/8).
- `KEEP_LEN_W`, default 4: width of the per-beat byte count; must hold KEEP_W.
- `LEN_W`, default 16: width of the accumulated message length.
- `clk`  in  1  clock. Single clock domain.
- `rst`  in  1  reset. Synchronous, active-high.
- `valid_i`  in  1  beat valid.
- `ready_o`  out  1  beat accepted when valid_i && ready_o.
- `keep_i`  in  KEEP_W  byte-keep mask, thermometer-aligned.
- `last_i`  in  1  last beat of the message.
- `len_v_o`  out  1  result valid; held until accepted.
- `len_ready_i`  in  1  result consumed when len_v_o && len_ready_i.
- `len_o`  out  LEN_W  total bytes in the message.
- `err_o`  out  1  message had a malformed mask or length overflow; valid with len_v_o.

## Operation
- Beat byte count `blen` = number of ones in `keep_i`.
- `keep_i` is legal when it is a thermometer (0 to KEEP_W ones, contiguous from the aligned end).
- Legality is per beat:
  - Non-last beat: `keep_i` must be all ones; anything else sets the sticky per-message error.
  - Last beat: any legal thermometer is allowed, including all zeros.
  - An illegal mask still adds its popcount to the length and sets the error.
- Accumulator `acc` (LEN_W+1 bits internally).
  - On an accepted beat: `acc <= acc + blen`.
  - If the sum exceeds 2^LEN_W−1: `len_o` saturates to all ones and the error is set.
- FSM states:
  - IDLE: acc=0, err=0. A non-last beat goes to ACC. A last beat goes to DONE.
  - ACC: mid-message. A non-last beat stays in ACC. A last beat goes to DONE.
  - DONE: `len_v_o`=1, `len_o` and `err_o` stable. On `len_ready_i`:
    - go to IDLE, clearing acc and err; or
    - if a new beat is accepted in the same cycle, process it as the first beat of the next message (to ACC or DONE).
- `ready_o` = (state != DONE) || `len_ready_i`. This is combinational, with no bubble between messages.
- Reset mid-message discards the partial length. No result is emitted for it.

## Timing
- Reset values: `len_v_o`=0, `len_o`=0, `err_o`=0, state IDLE, acc=0. `ready_o`=1 after reset.
- Latency: `len_v_o` rises on the clock edge that accepts the last beat. A result is therefore visible 1 cycle after the last beat.
- Single-beat message: the result is visible 1 cycle after the beat.
- Throughput: one beat per cycle. Back-to-back single-beat messages sustain one result per cycle if `len_ready_i` is held high.
- While DONE with `len_ready_i`=0: `ready_o`=0 and the inputs are ignored. Outputs hold stable (no valid drop, no value change).
- `valid_i`=0 cycles inside a message leave acc and state unchanged.
- `rst` has priority over all other events in the same cycle.

## Configuration
- `KEEP_MSB_EN` defined: masks are MSB-aligned. N bytes means keep[KEEP_W-1 -: N] set, e.g. 2 bytes = 8'b1100_0000.
  - The legality check is mirrored.
  - Non-last beats still require all ones.
- `KEEP_MSB_EN` undefined: masks are LSB-aligned, e.g. 2 bytes = 8'b0000_0011.

## Test plan
- 3-beat message, keep 8'hFF, 8'hFF, 8'h07 (last), LSB mode: `len_o`=19, `err_o`=0, `len_v_o` 1 cycle after the last beat.
- Single-beat message, keep 8'h00 with last: `len_o`=0, `err_o`=0. Next message, keep 8'hFF with last: `len_o`=8.
- Non-last beat keep 8'h0F, then last beat 8'hFF: `len_o`=12, `err_o`=1. The following clean message has `err_o`=0.
- Illegal last mask 8'h05: `len_o`=2, `err_o`=1. With `KEEP_MSB_EN`, last mask 8'hE0: `len_o`=3, `err_o`=0, and 8'h07 gives `err_o`=1.
- Backpressure: `len_ready_i`=0 for 4 cycles after the result. `ready_o`=0 and `len_o` is held. Raise `len_ready_i` together with a new last beat 8'h01: the next result is `len_o`=1 on the following cycle.
- LEN_W=6:
  - 9 beats of 8'hFF with last → `len_o`=63, `err_o`=1 (saturated).
  - Reset asserted after 2 beats of a message: `len_v_o`=0 and the next message counts from 0.
